// File: rtl/mult4u_product_accumulator.sv
// Accumulates a programmable count of unsigned product terms into one sum and
// presents it on a valid/ready handshake with a sticky carry-out flag.
module mult4u_product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  num_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W:0]     add_full;

  assign in_ready  = ~rst & (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign sum       = acc_q;
  assign overflow  = ovf_q;

  assign accept   = in_valid & in_ready;
  // One extra bit captures the carry out of the accumulator width.
  assign add_full = {1'b0, acc_q} + (ACC_W + 1)'(product);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d = ACC_W'(product);
          ovf_d = 1'b0;
          // A count of 0 behaves as 1: the first term completes the sum.
          if (num_terms <= LEN_W'(1)) begin
            rem_d   = '0;
            state_d = StHold;
          end else begin
            rem_d   = num_terms - LEN_W'(1);
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d = add_full[ACC_W-1:0];
          ovf_d = ovf_q | add_full[ACC_W];
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/mult4u_product_accumulator.md
Name: mult4u_product_accumulator

Overview:
- Downstream consumer of the registered 4x4 unsigned multiplier wrapper's 8-bit product.
- Accumulates a programmable number of consecutive products into one sum (dot-product reduction).
- Presents each completed sum on a valid/ready output handshake with a sticky overflow flag.
- Upstream control asserts in_valid aligned to the cycle the wrapper's registered product carries the intended term.

Parameters:
- PROD_W, 8, product input width (wrapper output width)
- ACC_W, 16, accumulator and sum width; must be >= PROD_W
- LEN_W, 8, width of num_terms

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- num_terms  input  LEN_W  terms per sum; sampled only on the first accepted product of a sum; 0 treated as 1
- in_valid  input  1  product is valid this cycle
- in_ready  output  1  block accepts product this cycle
- product  input  PROD_W  unsigned product term
- out_valid  output  1  sum/overflow valid
- out_ready  input  1  consumer takes sum
- sum  output  ACC_W  accumulated sum, modulo 2^ACC_W
- overflow  output  1  set if any addition of this sum carried out of ACC_W bits
- busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, acc=0, remaining=0, overflow=0, out_valid=0. While rst is high, in_ready=0. Reset mid-sum discards the partial sum with no output. Reset also drops a pending HOLD result.
- Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- in_ready and out_valid are decoded from registered state only. There is no combinational in-to-out path.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: acc<=product (zero-extended), overflow<=0, remaining<=max(num_terms,1)-1. If that value is 0, go to HOLD; else go to ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept: {carry,acc}<=acc+product (ACC_W+1-bit add), overflow<=overflow|carry, remaining<=remaining-1. If remaining was 1, go to HOLD. Cycles with in_valid=0 leave everything unchanged (gaps allowed, no timeout).
  - HOLD: in_ready=0, out_valid=1. sum and overflow stay stable until the handshake. On handshake, go to IDLE.
- sum is driven from acc at all times. It is only meaningful while out_valid=1.
- Latency: out_valid rises on the cycle after the accept of the last term.
- Throughput: N terms take N accept cycles plus at least 1 HOLD cycle. There is one mandatory bubble between sums (in_ready=0 in HOLD even when out_ready=1).
- num_terms changes during ACCUM/HOLD have no effect on the current sum.
- Wrap: acc wraps modulo 2^ACC_W. overflow is sticky within a sum and cleared when the next sum starts.
- product bits are don't-care when in_valid=0.

Test Plan:
- Reset then num_terms=4, product 225 on 4 back-to-back cycles, out_ready=1 -> out_valid=1 for exactly one cycle, 1 cycle after the 4th accept; sum=900, overflow=0; in_ready=1 on the following cycle.
- num_terms=1 with product 13, then num_terms=0 with product 7 -> two sums, 13 then 7, each out_valid 1 cycle after its single accept.
- num_terms=3, products 10,20,30 with in_valid low for 2 cycles between terms; out_ready low for 5 cycles after out_valid rises -> sum=60 held stable with out_valid=1 and in_ready=0 throughout; IDLE on the cycle after out_ready=1.
- ACC_W=10, num_terms=5, product 225 x5 -> sum=101 (1125 mod 1024), overflow=1. Next sum num_terms=2, products 1,2 -> sum=3, overflow=0.
- num_terms=255, product 225 x255 -> sum=57375, overflow=0, out_valid exactly 1 cycle after the 255th accept.
- num_terms=4, 2 terms accepted, then rst=1 for 1 cycle -> no out_valid. A subsequent num_terms=2 sum of 5,6 -> sum=11.
